// File: rtl/tinynpu_ctrl_ml.sv
// Multi-layer sequencer for the TinyNPU MAC array. It runs load, MAC streaming and drain for each layer.
// Between layers it writes array outputs back into the X FIFO. After the last layer it streams the results to the host.
module tinynpu_ctrl_ml #(
    parameter int SIZE       = 4,
    parameter int MAC_LAT    = 2,
    parameter int NUM_LAYERS = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              d2c_x_load_val,
    input  logic                              d2c_w_load_val,
    input  logic [$clog2(SIZE)-1:0]           d2c_w_load_sel,
    input  logic                              d2c_mac_val,
    input  logic                              d2c_x_fifo_empty,
    input  logic [SIZE-1:0]                   d2c_w_fifo_empty,
    input  logic                              d2c_out_rdy,
    output logic                              c2d_x_sel,
    output logic                              c2d_x_fifo_wen,
    output logic [SIZE-1:0]                   c2d_w_fifo_wen,
    output logic                              c2d_istream_val,
    output logic                              c2d_x_fifo_ren,
    output logic                              c2d_w_fifo_ren,
    output logic                              c2d_ostream_req,
    output logic [$clog2(SIZE)-1:0]           c2d_out_idx,
    output logic                              c2d_out_val,
    output logic                              c2d_done,
    output logic                              c2d_err,
    output logic [2:0]                        trace_state,
    output logic [$clog2(NUM_LAYERS+1)-1:0]   trace_layer
);

    localparam int IDX_W = $clog2(SIZE);
    localparam int LAY_W = $clog2(NUM_LAYERS + 1);
    localparam int LAT_W = $clog2(MAC_LAT) + 1;

    typedef enum logic [2:0] {
        S_LOAD  = 3'd0,
        S_MAC   = 3'd1,
        S_DRAIN = 3'd2,
        S_WB    = 3'd3,
        S_OUT   = 3'd4
    } state_t;

    state_t             r_state;
    logic [LAY_W-1:0]   r_layer;
    logic [LAT_W-1:0]   r_lat_cnt;
    logic [IDX_W-1:0]   r_idx;
    logic               r_err;

    state_t             w_state_nxt;
    logic [LAY_W-1:0]   w_layer_nxt;
    logic [LAT_W-1:0]   w_lat_nxt;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic               w_err_nxt;

    logic w_issue;
    logic w_all_empty;
    logic w_last_layer;
    logic w_last_idx;

    assign w_issue      = ~d2c_x_fifo_empty & ~|d2c_w_fifo_empty;
    assign w_all_empty  = d2c_x_fifo_empty & &d2c_w_fifo_empty;
    assign w_last_layer = (r_layer == LAY_W'(NUM_LAYERS - 1));
    assign w_last_idx   = (r_idx == IDX_W'(SIZE - 1));

    assign c2d_err     = r_err;
    assign trace_state = r_state;
    assign trace_layer = r_layer;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_LOAD;
            r_layer   <= '0;
            r_lat_cnt <= '0;
            r_idx     <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_layer   <= w_layer_nxt;
            r_lat_cnt <= w_lat_nxt;
            r_idx     <= w_idx_nxt;
            r_err     <= w_err_nxt;
        end
    end

    // Strobes are held low while rst is asserted, so a mid-operation reset issues no further FIFO or stream strobes.
    always_comb begin
        w_state_nxt     = r_state;
        w_layer_nxt     = r_layer;
        w_lat_nxt       = r_lat_cnt;
        w_idx_nxt       = r_idx;
        w_err_nxt       = r_err;
        c2d_x_sel       = 1'b0;
        c2d_x_fifo_wen  = 1'b0;
        c2d_w_fifo_wen  = '0;
        c2d_istream_val = 1'b0;
        c2d_x_fifo_ren  = 1'b0;
        c2d_w_fifo_ren  = 1'b0;
        c2d_ostream_req = 1'b0;
        c2d_out_idx     = '0;
        c2d_out_val     = 1'b0;
        c2d_done        = 1'b0;
        if (!rst) begin
            case (r_state)
                S_LOAD: begin
                    // Host X is only accepted for layer 0; later layers get X from write-back.
                    c2d_x_fifo_wen = d2c_x_load_val & (r_layer == '0);
                    for (int i = 0; i < SIZE; i++) begin
                        c2d_w_fifo_wen[i] = d2c_w_load_val & (d2c_w_load_sel == IDX_W'(i));
                    end
                    if (d2c_mac_val) w_state_nxt = S_MAC;
                end
                S_MAC: begin
                    if (w_issue) begin
                        c2d_istream_val = 1'b1;
                        c2d_x_fifo_ren  = 1'b1;
                        c2d_w_fifo_ren  = 1'b1;
                    end else if (w_all_empty) begin
                        w_state_nxt = S_DRAIN;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (r_lat_cnt == LAT_W'(MAC_LAT - 1)) begin
                        c2d_ostream_req = 1'b1;
                        w_lat_nxt       = '0;
                        w_idx_nxt       = '0;
                        w_state_nxt     = w_last_layer ? S_OUT : S_WB;
                    end else begin
                        w_lat_nxt = r_lat_cnt + LAT_W'(1);
                    end
                end
                S_WB: begin
                    c2d_x_sel      = 1'b1;
                    c2d_x_fifo_wen = 1'b1;
                    c2d_out_idx    = r_idx;
                    if (w_last_idx) begin
                        w_idx_nxt   = '0;
                        w_layer_nxt = r_layer + LAY_W'(1);
                        w_state_nxt = S_LOAD;
                    end else begin
                        w_idx_nxt = r_idx + IDX_W'(1);
                    end
                end
                S_OUT: begin
                    c2d_out_val = 1'b1;
                    c2d_out_idx = r_idx;
                    if (d2c_out_rdy) begin
                        if (w_last_idx) begin
                            c2d_done    = 1'b1;
                            w_idx_nxt   = '0;
                            w_layer_nxt = '0;
                            w_state_nxt = S_LOAD;
                        end else begin
                            w_idx_nxt = r_idx + IDX_W'(1);
                        end
                    end
                end
                default: w_state_nxt = S_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_tinynpu_ctrl_ml.sv
// Directed bench for tinynpu_ctrl_ml: stimulus pushes per-cycle expectations, a negedge monitor pops and compares.
// A second single-layer instance shares the inputs to cover the DRAIN -> OUT path.
module tb_tinynpu_ctrl_ml;

    localparam logic [2:0] ST_L = 3'd0, ST_M = 3'd1, ST_D = 3'd2, ST_W = 3'd3, ST_O = 3'd4;
    localparam int W = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       d2c_x_load_val, d2c_w_load_val, d2c_mac_val, d2c_x_fifo_empty, d2c_out_rdy;
    logic [1:0] d2c_w_load_sel;
    logic [3:0] d2c_w_fifo_empty;

    logic       c2d_x_sel, c2d_x_fifo_wen, c2d_istream_val, c2d_x_fifo_ren, c2d_w_fifo_ren;
    logic       c2d_ostream_req, c2d_out_val, c2d_done, c2d_err;
    logic [3:0] c2d_w_fifo_wen;
    logic [1:0] c2d_out_idx, trace_layer;
    logic [2:0] trace_state;

    logic       s_x_sel, s_x_fifo_wen, s_istream_val, s_x_fifo_ren, s_w_fifo_ren;
    logic       s_ostream_req, s_out_val, s_done, s_err;
    logic [3:0] s_w_fifo_wen;
    logic [1:0] s_out_idx;
    logic [0:0] s_trace_layer;
    logic [2:0] s_trace_state;

    logic [W-1:0] exp_q[$];
    logic [5:0]   exp1_q[$];
    string        name_q[$];
    int           checks = 0;
    int           failures = 0;

    always #5 clk = ~clk;

    tinynpu_ctrl_ml #(.SIZE(4), .MAC_LAT(2), .NUM_LAYERS(2)) u_dut (
        .clk(clk), .rst(rst),
        .d2c_x_load_val(d2c_x_load_val), .d2c_w_load_val(d2c_w_load_val),
        .d2c_w_load_sel(d2c_w_load_sel), .d2c_mac_val(d2c_mac_val),
        .d2c_x_fifo_empty(d2c_x_fifo_empty), .d2c_w_fifo_empty(d2c_w_fifo_empty),
        .d2c_out_rdy(d2c_out_rdy),
        .c2d_x_sel(c2d_x_sel), .c2d_x_fifo_wen(c2d_x_fifo_wen), .c2d_w_fifo_wen(c2d_w_fifo_wen),
        .c2d_istream_val(c2d_istream_val), .c2d_x_fifo_ren(c2d_x_fifo_ren),
        .c2d_w_fifo_ren(c2d_w_fifo_ren), .c2d_ostream_req(c2d_ostream_req),
        .c2d_out_idx(c2d_out_idx), .c2d_out_val(c2d_out_val), .c2d_done(c2d_done),
        .c2d_err(c2d_err), .trace_state(trace_state), .trace_layer(trace_layer)
    );

    tinynpu_ctrl_ml #(.SIZE(4), .MAC_LAT(2), .NUM_LAYERS(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .d2c_x_load_val(d2c_x_load_val), .d2c_w_load_val(d2c_w_load_val),
        .d2c_w_load_sel(d2c_w_load_sel), .d2c_mac_val(d2c_mac_val),
        .d2c_x_fifo_empty(d2c_x_fifo_empty), .d2c_w_fifo_empty(d2c_w_fifo_empty),
        .d2c_out_rdy(d2c_out_rdy),
        .c2d_x_sel(s_x_sel), .c2d_x_fifo_wen(s_x_fifo_wen), .c2d_w_fifo_wen(s_w_fifo_wen),
        .c2d_istream_val(s_istream_val), .c2d_x_fifo_ren(s_x_fifo_ren),
        .c2d_w_fifo_ren(s_w_fifo_ren), .c2d_ostream_req(s_ostream_req),
        .c2d_out_idx(s_out_idx), .c2d_out_val(s_out_val), .c2d_done(s_done),
        .c2d_err(s_err), .trace_state(s_trace_state), .trace_layer(s_trace_layer)
    );

    // Expected vector: {state, layer, x_sel, x_wen, w_wen[3:0], istream, x_ren, w_ren, ostream_req, out_idx, out_val, done, err}
    function automatic logic [W-1:0] ev(input logic [2:0] st, input logic [1:0] ly, input logic xs, input logic xw,
                                        input logic [3:0] ww, input logic rd, input logic osr, input logic [1:0] idx,
                                        input logic ov, input logic dn, input logic er);
        return {st, ly, xs, xw, ww, rd, rd, rd, osr, idx, ov, dn, er};
    endfunction

    function automatic logic [10:0] in_v(input logic xl, input logic wl, input logic [1:0] sel, input logic mv,
                                         input logic xe, input logic [3:0] we, input logic rdy);
        return {xl, wl, sel, mv, xe, we, rdy};
    endfunction

    function automatic logic [5:0] e1v(input logic [2:0] st, input logic ov, input logic dn);
        return {1'b1, st, ov, dn};
    endfunction

    // One clock cycle: apply inputs just after the edge and queue what both instances should show during it.
    task automatic cyc(input logic [10:0] in, input logic [W-1:0] exp, input string nm, input logic [5:0] e1 = 6'd0);
        @(posedge clk);
        #1;
        {d2c_x_load_val, d2c_w_load_val, d2c_w_load_sel, d2c_mac_val,
         d2c_x_fifo_empty, d2c_w_fifo_empty, d2c_out_rdy} = in;
        exp_q.push_back(exp);
        exp1_q.push_back(e1);
        name_q.push_back(nm);
    endtask

    task automatic set_idle();
        {d2c_x_load_val, d2c_w_load_val, d2c_w_load_sel, d2c_mac_val,
         d2c_x_fifo_empty, d2c_w_fifo_empty, d2c_out_rdy} = in_v(0, 0, 2'd0, 0, 1, 4'hF, 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        set_idle();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // One layer with no data: start MAC, see all-empty, drain, then write back if not last.
    task automatic layer_pass(input logic [1:0] ly, input logic er);
        logic [10:0] idle;
        idle = in_v(0, 0, 2'd0, 0, 1, 4'hF, 0);
        cyc(in_v(0, 0, 2'd0, 1, 1, 4'hF, 0), ev(ST_L, ly, 0, 0, 4'h0, 0, 0, 2'd0, 0, 0, er), "lp_start");
        cyc(idle, ev(ST_M, ly, 0, 0, 4'h0, 0, 0, 2'd0, 0, 0, er), "lp_mac_empty");
        cyc(idle, ev(ST_D, ly, 0, 0, 4'h0, 0, 0, 2'd0, 0, 0, er), "lp_drain0");
        cyc(idle, ev(ST_D, ly, 0, 0, 4'h0, 0, 1, 2'd0, 0, 0, er), "lp_drain_req");
        if (ly == 2'd0) begin
            for (int k = 0; k < 4; k++)
                cyc(idle, ev(ST_W, 2'd0, 1, 1, 4'h0, 0, 0, 2'(k), 0, 0, er), "lp_wb");
        end
    endtask

    logic [W-1:0] m_got, m_exp;
    logic [5:0]   m_exp1;
    logic [4:0]   m_got1;
    string        m_nm;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            m_exp  = exp_q.pop_front();
            m_exp1 = exp1_q.pop_front();
            m_nm   = name_q.pop_front();
            m_got  = {trace_state, trace_layer, c2d_x_sel, c2d_x_fifo_wen, c2d_w_fifo_wen, c2d_istream_val,
                      c2d_x_fifo_ren, c2d_w_fifo_ren, c2d_ostream_req, c2d_out_idx, c2d_out_val, c2d_done, c2d_err};
            checks++;
            if (m_got !== m_exp) begin
                failures++;
                $display("FAIL %s @%0t: got %05h expected %05h", m_nm, $time, m_got, m_exp);
            end
            if (m_exp1[5]) begin
                m_got1 = {s_trace_state, s_out_val, s_done};
                checks++;
                if (m_got1 !== m_exp1[4:0]) begin
                    failures++;
                    $display("FAIL %s_single @%0t: got %02h expected %02h", m_nm, $time, m_got1, m_exp1[4:0]);
                end
            end
        end
    end

    logic [10:0] idle;
    logic [6:0]  rdy_pat;
    logic [1:0]  idx_tab[7];

    initial begin
        idle    = in_v(0, 0, 2'd0, 0, 1, 4'hF, 0);
        rdy_pat = 7'b1011001;   // LSB first: 1,0,0,1,1,0,1
        idx_tab = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd3, 2'd3};
        set_idle();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        cyc(idle, ev(ST_L, 2'd0, 0, 0, 4'h0, 0, 0, 2'd0, 0, 0, 0), "reset_state", e1v(ST_L, 0, 0));
        for (int k = 0; k < 4; k++)
            cyc(in_v(1, 1, 2'(k), 0, 1, 4'hF, 0),
                ev(ST_L, 2'd0, 0, 1, 4'b0001 << k, 0, 0, 2'd0, 0, 0, 0), "load_l0_wsel");
        cyc(in_v(1, 0, 2'd0, 1, 1, 4'hF, 0), ev(ST_L, 2'd0, 0, 1, 4'h0, 0, 0, 2'd0, 0, 0, 0), "mac_start_load");
        for (int k = 0; k < 4; k++)
            cyc(in_v(1, 1, 2'(k), 1, 0, 4'h0, 0), ev(ST_M, 2'd0, 0, 0, 4'h0, 1, 0, 2'd0, 0, 0, 0), "mac_issue");
        cyc(in_v(0, 0, 2'd0, 0, 0, 4'b0100, 0), ev(ST_M, 2'd0, 0, 0, 4'h0, 0, 0, 2'd0, 0, 0, 0), "mac_partial");
        cyc(in_v(0, 0, 2'd0, 0, 0, 4'b0100, 0), ev(ST_M, 2'd0, 0, 0, 4'h0, 0, 0, 2'd0, 0, 0, 1), "mac_stall_err");
        cyc(idle, ev(ST_M, 2'd0, 0, 0, 4'h0, 0, 0, 2'd0, 0, 0, 1), "mac_all_empty");
        cyc(idle, ev(ST_D, 2'd0, 0, 0, 4'h0, 0, 0, 2'd0, 0, 0, 1), "drain0", e1v(ST_D, 0, 0));
        cyc(idle, ev(ST_D, 2'd0, 0, 0, 4'h0, 0, 1, 2'd0, 0, 0, 1), "drain_req", e1v(ST_D, 0, 0));
        for (int k = 0; k < 4; k++)
            cyc(in_v(1, 1, 2'd2, 0, 1, 4'hF, 0), ev(ST_W, 2'd0, 1, 1, 4'h0, 0, 0, 2'(k), 0, 0, 1), "wb",
                e1v(ST_O, 1, 0));
        cyc(in_v(1, 1, 2'd2, 0, 1, 4'hF, 0), ev(ST_L, 2'd1, 0, 0, 4'b0100, 0, 0, 2'd0, 0, 0, 1), "load_l1_xign");
        cyc(in_v(0, 0, 2'd0, 1, 1, 4'hF, 0), ev(ST_L, 2'd1, 0, 0, 4'h0, 0, 0, 2'd0, 0, 0, 1), "mac_start_l1");
        for (int k = 0; k < 2; k++)
            cyc(in_v(0, 0, 2'd0, 0, 0, 4'h0, 0), ev(ST_M, 2'd1, 0, 0, 4'h0, 1, 0, 2'd0, 0, 0, 1), "mac_issue_l1");
        cyc(idle, ev(ST_M, 2'd1, 0, 0, 4'h0, 0, 0, 2'd0, 0, 0, 1), "mac_all_empty_l1");
        cyc(idle, ev(ST_D, 2'd1, 0, 0, 4'h0, 0, 0, 2'd0, 0, 0, 1), "drain0_l1");
        cyc(idle, ev(ST_D, 2'd1, 0, 0, 4'h0, 0, 1, 2'd0, 0, 0, 1), "drain_req_l1");
        for (int k = 0; k < 7; k++)
            cyc(in_v(0, 0, 2'd0, 0, 1, 4'hF, rdy_pat[k]),
                ev(ST_O, 2'd1, 0, 0, 4'h0, 0, 0, idx_tab[k], 1, (k == 6), 1), "out_bp",
                e1v(ST_O, 1, (k == 6)));
        cyc(idle, ev(ST_L, 2'd0, 0, 0, 4'h0, 0, 0, 2'd0, 0, 0, 1), "after_done", e1v(ST_L, 0, 0));

        cyc(in_v(0, 0, 2'd0, 1, 1, 4'hF, 0), ev(ST_L, 2'd0, 0, 0, 4'h0, 0, 0, 2'd0, 0, 0, 1), "mac_start_r1");
        cyc(idle, ev(ST_M, 2'd0, 0, 0, 4'h0, 0, 0, 2'd0, 0, 0, 1), "mac_empty_r1");
        cyc(idle, ev(ST_D, 2'd0, 0, 0, 4'h0, 0, 0, 2'd0, 0, 0, 1), "drain_pre_rst");
        do_reset();
        for (int k = 0; k < 3; k++)
            cyc(in_v(0, 0, 2'd0, 0, 1, 4'hF, 1), ev(ST_L, 2'd0, 0, 0, 4'h0, 0, 0, 2'd0, 0, 0, 0),
                "post_rst_drain", e1v(ST_L, 0, 0));

        layer_pass(2'd0, 1'b0);
        layer_pass(2'd1, 1'b0);
        cyc(in_v(0, 0, 2'd0, 0, 1, 4'hF, 1), ev(ST_O, 2'd1, 0, 0, 4'h0, 0, 0, 2'd0, 1, 0, 0), "out_hs0");
        cyc(idle, ev(ST_O, 2'd1, 0, 0, 4'h0, 0, 0, 2'd1, 1, 0, 0), "out_wait");
        do_reset();
        for (int k = 0; k < 3; k++)
            cyc(in_v(0, 0, 2'd0, 0, 1, 4'hF, 1), ev(ST_L, 2'd0, 0, 0, 4'h0, 0, 0, 2'd0, 0, 0, 0),
                "post_rst_out", e1v(ST_L, 0, 0));

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tinynpu_ctrl_ml.md
Name: tinynpu_ctrl_ml

Overview:
- Multi-layer control FSM for the TinyNPU SIZE x SIZE MAC array.
- Sequences per-layer weight loading, MAC streaming and pipeline drain.
- Between layers, writes back array outputs as the next layer's X input. On the last layer, streams results to the host over a valid/ready handshake.
- Sits between the host load interface and the TinyNPU datapath (X/W FIFOs, MAC array, output register).

Parameters:
- SIZE, 4: array dimension; number of W FIFOs and output words per layer.
- MAC_LAT, 2: MAC array pipeline latency in cycles, >= 1.
- NUM_LAYERS, 2: layers per inference, >= 1.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- d2c_x_load_val  in  1  host X word valid
- d2c_w_load_val  in  1  host W word valid
- d2c_w_load_sel  in  $clog2(SIZE)  target W FIFO for host W word
- d2c_mac_val  in  1  host: layer inputs loaded, start MAC
- d2c_x_fifo_empty  in  1  X FIFO empty
- d2c_w_fifo_empty  in  SIZE  W FIFO i empty, bit i
- d2c_out_rdy  in  1  host ready for an output word
- c2d_x_sel  out  1  X FIFO write source: 0 = host, 1 = array output
- c2d_x_fifo_wen  out  1  X FIFO write enable
- c2d_w_fifo_wen  out  SIZE  W FIFO write enables, one-hot or zero
- c2d_istream_val  out  1  MAC input stream valid
- c2d_x_fifo_ren  out  1  X FIFO read
- c2d_w_fifo_ren  out  1  all W FIFOs read
- c2d_ostream_req  out  1  capture array outputs into output register
- c2d_out_idx  out  $clog2(SIZE)  output word select (write-back and OUT)
- c2d_out_val  out  1  output word valid to host
- c2d_done  out  1  one-cycle pulse: inference complete
- c2d_err  out  1  sticky: FIFO empty mismatch during MAC
- trace_state  out  3  current state encoding
- trace_layer  out  $clog2(NUM_LAYERS+1)  current layer index

Behaviour:
- States: LOAD=0, MAC=1, DRAIN=2, WB=3, OUT=4.
- Reset: state=LOAD, layer=0, lat_cnt=0, idx=0, err=0. All outputs 0.
- LOAD:
  - c2d_x_sel=0.
  - c2d_x_fifo_wen = d2c_x_load_val, only when layer==0; host X is ignored for layer>0.
  - c2d_w_fifo_wen[i] = d2c_w_load_val & (d2c_w_load_sel==i).
  - Go to MAC on d2c_mac_val. Loads in that same cycle are still written.
- MAC:
  - issue = ~x_empty & ~|w_empty. When issue: istream_val = x_ren = w_ren = 1.
  - all_empty = x_empty & &w_empty. When all_empty, go to DRAIN next cycle.
  - If neither issue nor all_empty (partial empty): stall with no reads, set err. err clears only on rst.
- DRAIN:
  - lat_cnt increments each cycle.
  - When lat_cnt == MAC_LAT-1: assert c2d_ostream_req for one cycle, clear lat_cnt, clear idx.
  - Next state is WB if layer < NUM_LAYERS-1, else OUT.
  - ostream_req therefore fires exactly MAC_LAT cycles after entering DRAIN.
- WB:
  - c2d_x_sel=1, c2d_x_fifo_wen=1, c2d_out_idx=idx; idx increments each cycle.
  - Runs exactly SIZE cycles.
  - After the idx==SIZE-1 cycle: layer++, state=LOAD.
- OUT:
  - c2d_out_val=1, c2d_out_idx=idx.
  - idx advances only when d2c_out_rdy is high; out_val stays high while waiting.
  - On handshake at idx==SIZE-1: c2d_done=1 that cycle, layer=0, state=LOAD.
- Outside their listed states, all FIFO enables and stream signals are 0. c2d_x_sel is 0 except in WB.
- d2c_mac_val outside LOAD is ignored. Host load valids outside LOAD are ignored (no writes).
- rst mid-operation: returns to LOAD/layer 0 next cycle with no further FIFO strobes. FIFO contents are the datapath's responsibility.
- NUM_LAYERS=1: DRAIN always goes to OUT; WB is never entered.

Test Plan:
- Single layer, SIZE=4, MAC_LAT=2: load 4 X and 4 W per FIFO, pulse mac_val, FIFOs drain after 4 issues -> istream_val high 4 cycles; ostream_req exactly 2 cycles after DRAIN entry; OUT idx 0..3 with rdy=1; done pulses with idx=3.
- Two layers: after layer 0 drain -> WB with x_sel=1, x_fifo_wen high exactly 4 cycles, out_idx 0,1,2,3; then LOAD with trace_layer=1; host X load in LOAD ignored (x_fifo_wen=0).
- Backpressure: in OUT, rdy toggles 1,0,0,1,1,0,1 -> idx advances only on rdy=1; out_val stays high; done on 4th handshake.
- Partial empty: x_empty=0, w_empty[2]=1 in MAC -> no reads, err=1, state stays MAC; then all empty -> DRAIN; err remains 1 until rst.
- W select decode: w_load_val with sel=0..3 in LOAD -> only wen[sel] asserted; same stimulus in MAC -> all wen=0.
- Reset mid-DRAIN and mid-OUT: rst high one cycle -> state=LOAD, layer=0, all outputs 0; ostream_req and done never asserted afterwards until a new mac_val.
